// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioning chain.
package button_pkg;

  // Auto-repeat states: waiting for a press, holding off the first repeat, repeating.
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  // Millisecond duration converted to a whole number of clk cycles.
  function automatic int ms_to_cycles(input int hz, input int ms);
    return hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle: the raw input and the conditioned outputs.
interface button_conditioner_if;
  logic btn_raw;
  logic btn_level;
  logic press;
  logic release_pulse;
  logic step;

  // Board/bench side: drives the raw button, observes the pulses.
  modport master (
    output btn_raw,
    input  btn_level,
    input  press,
    input  release_pulse,
    input  step
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output press,
    output release_pulse,
    output step
  );
endinterface

// File: rtl/button_conditioner_debouncer.sv
// Two-flop synchroniser followed by a stability counter. Also used on its own
// for slide switches. dout_next is the value dout takes at the next edge; it
// comes only from flops, so the raw input never reaches it combinationally.
module debouncer
  import button_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic dout,
  output logic dout_next
);

  localparam int DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CW     = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC);

  if (DB_CYC < 1) begin : g_bad_db
    $error("debouncer: DEBOUNCE_MS yields fewer than 1 clock cycle");
  end

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          btn_sync;
  logic          differ;
  logic          hit;

  assign btn_sync  = sync_reg[1];
  assign differ    = (btn_sync != level_reg);
  // Input has disagreed with the level for DB_CYC cycles and still does.
  assign hit       = differ && (cnt_reg == CNT_MAX);
  assign dout_next = hit ? btn_sync : level_reg;
  assign dout      = level_reg;

  // Synchronise, count disagreement, adopt the new level once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], din_async};
      level_reg <= dout_next;
      if (!differ || hit) cnt_reg <= '0;
      else                cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Raw bouncy button -> debounced level, press/release pulses and a step pulse
// with optional hold-to-repeat. step is meant to drive a counter's dec input.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter bit REPEAT_EN       = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  button_conditioner_if.slave  bus
);

  localparam int DLY_CYC  = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RATE_CYC = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
  localparam int MAX_CYC  = (DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC;
  localparam int RW       = $clog2(MAX_CYC + 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(DLY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(RATE_CYC - 1);

  if (DLY_CYC < 1) begin : g_bad_dly
    $error("button_conditioner: REPEAT_DELAY_MS yields fewer than 1 clock cycle");
  end
  // A one-cycle rate would make step high on back-to-back cycles.
  if (RATE_CYC < 2) begin : g_bad_rate
    $error("button_conditioner: REPEAT_RATE_MS yields fewer than 2 clock cycles");
  end

  logic          level;
  logic          level_next;
  logic          rise;
  logic          fall;
  logic          press_reg;
  logic          release_reg;
  logic          step_reg;
  rpt_state_t    state_reg;
  logic [RW-1:0] cnt_reg;

  debouncer #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .din_async (bus.btn_raw),
    .dout      (level),
    .dout_next (level_next)
  );

  // Edges are taken from the level about to be registered so the pulses line
  // up with the first cycle the new level is visible.
  assign rise = level_next & ~level;
  assign fall = ~level_next & level;

  // Registered press/release pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      press_reg   <= rise;
      release_reg <= fall;
    end
  end

  // Auto-repeat FSM; a release in the same cycle as a repeat tick wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      step_reg  <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      if (!level_next) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rise) begin
              step_reg  <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= DELAY;
            end
          end
          DELAY: begin
            if (REPEAT_EN) begin
              if (cnt_reg == DLY_LAST) begin
                step_reg  <= 1'b1;
                cnt_reg   <= '0;
                state_reg <= REPEAT;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (cnt_reg == RATE_LAST) begin
              step_reg <= 1'b1;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level     = level;
  assign bus.press         = press_reg;
  assign bus.release_pulse = release_reg;
  assign bus.step          = step_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: 1 ms = 1 cycle, debounce 4, repeat delay 10, repeat rate 3.
// dut_a has auto-repeat, dut_b has it disabled. Outputs are compared as the
// packed vector {btn_level, press, release, step}, sampled 1 ns after each edge.
module tb_button_conditioner;
  import button_pkg::*;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  button_conditioner_if bus_a ();
  button_conditioner_if bus_b ();

  always #5 clk = ~clk;

  button_conditioner #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS(3), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  button_conditioner #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS(3), .REPEAT_EN(1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs_a();
    return {bus_a.btn_level, bus_a.press, bus_a.release_pulse, bus_a.step};
  endfunction

  function automatic logic [3:0] outs_b();
    return {bus_b.btn_level, bus_b.press, bus_b.release_pulse, bus_b.step};
  endfunction

  logic bounce [16];
  logic lvl, prs, rel, stp;

  initial begin
    bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held 3 cycles with the button pressed: everything stays 0.
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.btn_raw = 1'b1;
    bus_b.btn_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("reset c%0d", i), 32'(outs_a()), 32'h0);
    end
    bus_a.btn_raw = 1'b0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    repeat (8) tick();
    check_eq("idle after reset", 32'(outs_a()), 32'h0);

    // Press at t=1 -> level/press/step at t=7, repeats at 17,20,23,26,
    // raw low sampled at t=21 -> release at t=27.
    bus_a.btn_raw = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 20) bus_a.btn_raw = 1'b0;
      lvl = (t >= 7) && (t <= 26);
      prs = (t == 7);
      rel = (t == 27);
      stp = (t == 7) || (t == 17) || (t == 20) || (t == 23) || (t == 26);
      check_eq($sformatf("hold t%0d", t), 32'(outs_a()), 32'({lvl, prs, rel, stp}));
    end

    // Bounce: high 3, low 1, high 3, low -> nothing gets through.
    for (int i = 0; i < 16; i++) begin
      bus_a.btn_raw = bounce[i];
      tick();
      check_eq($sformatf("bounce c%0d", i), 32'(outs_a()), 32'h0);
    end

    // Release landing on the press+13 repeat tick (t=20): no step, FSM idle.
    bus_a.btn_raw = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (t == 13) bus_a.btn_raw = 1'b0;
      lvl = (t >= 7) && (t <= 19);
      prs = (t == 7);
      rel = (t == 20);
      stp = (t == 7) || (t == 17);
      check_eq($sformatf("relrpt t%0d", t), 32'(outs_a()), 32'({lvl, prs, rel, stp}));
      if (t == 20) check_eq("relrpt idle", 32'(dut_a.state_reg), 32'(IDLE));
    end

    // No auto-repeat: one step with press; reset during the hold (edges 21,22)
    // then a fresh press 6 edges after reset deasserts (t=29).
    bus_b.btn_raw = 1'b1;
    for (int t = 1; t <= 36; t++) begin
      tick();
      if (t == 20) reset_b = 1'b1;
      if (t == 22) reset_b = 1'b0;
      lvl = ((t >= 7) && (t <= 20)) || (t >= 29);
      prs = (t == 7) || (t == 29);
      rel = 1'b0;
      stp = (t == 7) || (t == 29);
      check_eq($sformatf("norpt t%0d", t), 32'(outs_b()), 32'({lvl, prs, rel, stp}));
    end
    bus_b.btn_raw = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
